// File: rtl/uart_tx2.sv
// uart_tx2: FIFO-buffered UART transmitter, 5..8 data bits, 1 or 2 stops.
// Build option UART_TX2_PARITY_EN adds the even/odd parity bit stage.
module uart_tx2 #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PAYLOAD_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 cycles_per_bit,
  input  logic [1:0]                  char_len,
  input  logic                        stop2,
  input  logic [1:0]                  parity_mode,
  input  logic                        uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0]     uart_tx_data,
  output logic                        uart_txd,
  output logic                        uart_tx_busy,
  output logic                        tx_full,
  output logic                        tx_empty,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx_overflow,
  output logic                        tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX2_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------- transmit FIFO ----------------
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           count;
  logic                    push;
  logic                    pop;
  logic [PAYLOAD_BITS-1:0] head;

  assign tx_full  = count == LW'(FIFO_DEPTH);
  assign tx_empty = count == '0;
  assign tx_level = count;
  assign push     = uart_tx_en && !tx_full;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
      if (uart_tx_en && tx_full)
        tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= uart_tx_data;
  end

  // ---------------- frame configuration ----------------
  logic [3:0] nbits_in;

  always_comb begin
    nbits_in = 4'd5 + {2'b00, char_len};
    if (int'(nbits_in) > PAYLOAD_BITS)
      nbits_in = 4'(PAYLOAD_BITS);
  end

`ifdef UART_TX2_PARITY_EN
  logic par_in;
  logic par_en_in;
  logic par_en_q;
  logic par_bit_q;

  // Parity covers only the bits that actually go on the line.
  always_comb begin
    par_in = 1'b0;
    for (int i = 0; i < PAYLOAD_BITS; i++)
      if (i < int'(nbits_in))
        par_in = par_in ^ head[i];
    if (parity_mode == 2'b10)
      par_in = ~par_in;
  end

  assign par_en_in = (parity_mode == 2'b01) ||
                     (parity_mode == 2'b10);
`else
  logic unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  // ---------------- FSM / datapath ----------------
  state_t                  state_q;
  state_t                  state_d;
  logic [31:0]             cyc_cnt;
  logic [31:0]             cpb_q;
  logic [3:0]              bit_idx;
  logic [3:0]              nbits_q;
  logic                    stop_idx;
  logic                    stop2_q;
  logic [PAYLOAD_BITS-1:0] shreg_q;
  logic                    txd_q;
  logic                    txd_d;
  logic                    done_q;
  logic                    done_d;
  logic                    bit_end;
  logic                    last_data;
  logic                    last_stop;

  assign bit_end   = cyc_cnt == cpb_q;
  assign last_data = bit_idx == (nbits_q - 4'd1);
  assign last_stop = stop_idx == stop2_q;

  assign uart_txd     = txd_q;
  assign uart_tx_busy = state_q != IDLE;
  assign tx_done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_cnt  <= '0;
      cpb_q    <= '0;
      bit_idx  <= '0;
      nbits_q  <= '0;
      stop_idx <= 1'b0;
      stop2_q  <= 1'b0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX2_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
      // A pop latches the whole frame setup; later input changes wait.
      if (pop) begin
        cyc_cnt  <= '0;
        cpb_q    <= cycles_per_bit;
        bit_idx  <= '0;
        nbits_q  <= nbits_in;
        stop_idx <= 1'b0;
        stop2_q  <= stop2;
        shreg_q  <= head;
`ifdef UART_TX2_PARITY_EN
        par_en_q  <= par_en_in;
        par_bit_q <= par_in;
`endif
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          cyc_cnt <= '0;
          if (state_q == DATA) begin
            bit_idx <= bit_idx + 4'd1;
            shreg_q <= shreg_q >> 1;
          end
          if (state_q == STOP)
            stop_idx <= 1'b1;
        end else begin
          cyc_cnt <= cyc_cnt + 32'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (bit_end)
          state_d = DATA;
      end
      DATA: begin
        if (bit_end && last_data) begin
`ifdef UART_TX2_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX2_PARITY_EN
      PARITY: begin
        if (bit_end)
          state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end && last_stop) begin
          if (!tx_empty) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the state being entered.
  always_comb begin
    txd_d  = 1'b1;
    done_d = (state_q == STOP) && bit_end && last_stop;
    unique case (state_d)
      START: txd_d = 1'b0;
      DATA: begin
        if ((state_q == DATA) && bit_end)
          txd_d = shreg_q[1];
        else
          txd_d = shreg_q[0];
      end
`ifdef UART_TX2_PARITY_EN
      PARITY: txd_d = par_bit_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx2.md
UART_TX2 -- requirements
Module: uart_tx2

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8, data width and maximum character length.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port cycles_per_bit, input, 32, bit period minus one, in clk cycles.
REQ-006 SHALL have port char_len, input, 2, character length = 5+char_len bits (5..8), capped at PAYLOAD_BITS.
REQ-007 SHALL have port stop2, input, 1, 1 = two stop bits, 0 = one.
REQ-008 SHALL have port parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 none.
REQ-009 SHALL have port uart_tx_en, input, 1, write strobe, uart_tx_data into FIFO.
REQ-010 SHALL have port uart_tx_data, input, PAYLOAD_BITS, character to queue.
REQ-011 SHALL have port uart_txd, output, 1, serial line, registered.
REQ-012 SHALL have port uart_tx_busy, output, 1, high whenever FSM not IDLE.
REQ-013 SHALL have port tx_full / tx_empty, output, 1 each, FIFO status.
REQ-014 SHALL have port tx_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-015 SHALL have port tx_overflow, output, 1, sticky; write attempted while full.
REQ-016 SHALL have port tx_done, output, 1, one-cycle pulse at end of last stop bit.

Function
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 Each bit SHALL last exactly cycles_per_bit+1 clk cycles; cycles_per_bit=0 gives 1-cycle bits.
REQ-019 Write with tx_full=0 SHALL store uart_tx_data and increment tx_level the next edge.
REQ-020 Write with tx_full=1 SHALL be dropped (FIFO unchanged, even if a pop occurs the same cycle) and set tx_overflow.
REQ-021 Simultaneous accepted write and pop SHALL leave tx_level unchanged.
REQ-022 IDLE with tx_empty=0 SHALL pop one entry and enter START, with uart_txd going 0 on that same edge.
REQ-023 Write to empty FIFO while IDLE: uart_txd SHALL fall at the second rising edge, counting the edge that samples uart_tx_en.
REQ-024 char_len, stop2, parity_mode, cycles_per_bit SHALL be latched at the pop; mid-frame changes affect the next frame only.
REQ-025 DATA SHALL send char_len+5 bits LSB first; unused upper data bits ignored.
REQ-026 PARITY SHALL be entered only for modes 01/10; bit = XOR of sent data bits (even) or its inverse (odd).
REQ-027 STOP SHALL drive 1 for one or two bit periods per latched stop2.
REQ-028 At end of STOP, tx_done SHALL pulse; with FIFO non-empty, FSM SHALL go directly to START (no idle cycle), else to IDLE.
REQ-029 uart_txd SHALL be 1 in IDLE and during stop bits.
REQ-030 Frame length SHALL be (1+N+P+S)*(cycles_per_bit+1) cycles, N data, P parity (0/1), S stop bits.

Reset
REQ-031 reset SHALL force, at the next edge: FSM IDLE, uart_txd=1, uart_tx_busy=0, FIFO empty (tx_empty=1, tx_full=0, tx_level=0), tx_overflow=0, tx_done=0, counters 0.
REQ-032 reset mid-frame SHALL abort the frame immediately; no partial bits follow; writes during reset SHALL be ignored.

Configuration
REQ-033 With UART_TX2_PARITY_EN defined, parity SHALL follow REQ-026.
REQ-034 Without UART_TX2_PARITY_EN, PARITY state and logic SHALL be absent, parity_mode ignored, P=0 always.

Verification
REQ-035 cycles_per_bit=3, char_len=3, parity 00, stop2=0, write 0x55 -> uart_txd 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; 40 cycles; tx_done once.
REQ-036 (parity enabled) cycles_per_bit=1, char_len=2, parity 01, write 0x41 -> 7 data bits 1000001 (LSB first), parity 0, stop 1; 20 cycles; odd mode gives parity 1.
REQ-037 char_len=0, stop2=1, write 0xFF -> start, five 1s, two stop bits; 8 bit periods; upper 3 bits not sent.
REQ-038 FIFO_DEPTH=4, IDLE, 5 writes on consecutive cycles -> first pops immediately, 4 queued, 5th accepted or dropped per tx_full, tx_overflow set only if dropped; all accepted frames back-to-back, no idle gap; tx_empty and IDLE after last tx_done.
REQ-039 Assert reset mid data bit with 2 entries queued -> next edge uart_txd=1, busy=0, tx_level=0, tx_overflow=0; no further line activity.
